// File: rtl/tx_dispatch_if.sv
// Operation input port and per-instance switch port of the transmit dispatcher.
// The slave modport is the dispatcher's view; master is the driving environment.
interface tx_dispatch_if #(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8
);
  // Operation input (valid/ready)
  logic                           in_valid;
  logic                           in_ready;
  logic [7:0]                     in_addr;
  logic [W_WIDTH-1:0]             in_op_id;

  // Switch-instance side
  logic [NUM_SW_INST-1:0]         sw_req;
  logic [W_WIDTH*NUM_SW_INST-1:0] sw_op_id;
  logic [NUM_SW_INST-1:0]         sw_ack;

  // Completion status
  logic                           done;
  logic                           err;
  logic [1:0]                     err_code;
  logic                           busy;

  modport slave (
    input  in_valid, in_addr, in_op_id, sw_ack,
    output in_ready, sw_req, sw_op_id, done, err, err_code, busy
  );

  modport master (
    output in_valid, in_addr, in_op_id, sw_ack,
    input  in_ready, sw_req, sw_op_id, done, err, err_code, busy
  );
endinterface

// File: rtl/tx_dispatch.sv
// Transmit-side dispatcher: buffers {addr, op_id} operations in a 2-entry FIFO,
// decodes each to one switch instance and holds that instance's request and
// op-id slice until it acknowledges or the request times out.
module tx_dispatch #(
  parameter int         NUM_SW_INST = 5,
  parameter int         W_WIDTH     = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h10,
  parameter int         TIMEOUT     = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  tx_dispatch_if.slave bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int IDX_W = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int ENT_W = 8 + W_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Operation FIFO (2 entries)
  // ---------------------------------------------------------------------------
  logic [ENT_W-1:0] fifo_mem [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic [7:0]       head_addr;
  logic [W_WIDTH-1:0] head_op;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [W_WIDTH-1:0]   op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic [1:0]           code_q, code_d;

  assign fifo_full    = (count_q == 2'd2);
  assign fifo_empty   = (count_q == 2'd0);
  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  // The head is consumed on the same cycle the FSM looks at it in IDLE
  assign pop          = (state_q == IDLE) && !fifo_empty;

  assign head      = fifo_mem[rd_ptr_q];
  assign head_addr = head[ENT_W-1 -: 8];
  assign head_op   = head[W_WIDTH-1:0];

  // Entry storage carries no reset: occupancy is tracked by the pointers alone
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.in_addr, bus.in_op_id};
    end
  end

  // FIFO pointers and occupancy; push and pop together leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Address decode: 8-bit wrap makes addresses below the base land far out of range
  // ---------------------------------------------------------------------------
  logic [7:0] dec_off;
  logic       dec_hit;

  assign dec_off = head_addr - BASE_ADDR;
  assign dec_hit = (head_addr >= BASE_ADDR) && (dec_off < 8'(NUM_SW_INST));

  // ---------------------------------------------------------------------------
  // Dispatch FSM
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_inc;
  logic             ack_sel;

  assign cnt_inc = cnt_q + 1'b1;
  // Only the selected instance's ack matters; other bits are ignored
  assign ack_sel = bus.sw_ack[idx_q];

  // Next-state and pulse generation; an ack on the final request cycle beats the timeout
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = 2'b00;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          if (dec_hit) begin
            state_d = WAIT;
            idx_d   = dec_off[IDX_W-1:0];
            op_d    = head_op;
            cnt_d   = '0;
          end else begin
            err_d  = 1'b1;
            code_d = 2'b01;
          end
        end
      end
      WAIT: begin
        if (ack_sel) begin
          done_d  = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          code_d  = 2'b10;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, captured operation and status pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-instance request and op-id slices; unselected slices are forced to zero
  // ---------------------------------------------------------------------------
  logic [NUM_SW_INST-1:0]         sw_req_o;
  logic [W_WIDTH*NUM_SW_INST-1:0] sw_op_id_o;

  generate
    for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_inst
      assign sw_req_o[gi]                      = (state_q == WAIT) && (idx_q == IDX_W'(gi));
      assign sw_op_id_o[gi*W_WIDTH +: W_WIDTH] = sw_req_o[gi] ? op_q : '0;
    end
  endgenerate

  assign bus.sw_req   = sw_req_o;
  assign bus.sw_op_id = sw_op_id_o;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;
  assign bus.busy     = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/tx_dispatch.md
# tx_dispatch

Transmit-side dispatcher for the unit address decoder. Accepts operations (8-bit target address plus op id) through a valid/ready port and buffers them in a 2-entry FIFO. Each operation is decoded to one switch instance, and the block drives that instance's request line and op-id slice until the instance acknowledges or a timeout expires. The resulting per-instance op_id bus and ack vector are exactly what the receive-side mux consumes.

## Interface
- NUM_SW_INST, 5, number of switch instances served
- W_WIDTH, 8, op-id width
- BASE_ADDR, 8'h10, address of instance 0; instance i owns address BASE_ADDR+i
- TIMEOUT, 15, maximum request cycles waiting for ack (>=1); counter width is $clog2(TIMEOUT+1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  FIFO can accept; transfer occurs when in_valid && in_ready
- in_addr  in  8  target address
- in_op_id  in  W_WIDTH  operation id
- sw_req  out  NUM_SW_INST  one-hot request to the selected instance
- sw_op_id  out  W_WIDTH*NUM_SW_INST  slice i = op id for instance i; all non-selected slices are 0
- sw_ack  in  NUM_SW_INST  per-instance acknowledge
- done  out  1  one-cycle pulse: operation acknowledged
- err  out  1  one-cycle pulse: operation failed
- err_code  out  2  valid with err: 2'b01 decode miss, 2'b10 timeout; 0 otherwise
- busy  out  1  high when state != IDLE or FIFO is non-empty

## Operation
- FIFO: 2 entries of {addr, op_id}, first in, first out.
  - in_ready = !full, with combinational dependence on count only.
  - Push and pop in the same cycle leaves count unchanged.
  - A push while full is impossible, because in_ready is 0.
- FSM states are IDLE, WAIT. ERR and DONE are not states; they are registered pulses.
- IDLE:
  - If the FIFO is non-empty, pop the head and decode idx = addr - BASE_ADDR using 8-bit unsigned arithmetic.
  - Hit: addr >= BASE_ADDR and idx < NUM_SW_INST. Register the idx, load the op id, clear the counter, go to WAIT.
  - Miss: including addresses below BASE_ADDR, which wrap to a large idx. Pulse err with code 01 next cycle and stay in IDLE.
- WAIT:
  - sw_req[idx] = 1 and sw_op_id slice idx = op id, both held stable.
  - Each cycle, sample sw_ack[idx]. Acks on other bits are ignored.
  - Ack seen: done = 1 next cycle, sw_req/slice cleared in that same next cycle, go to IDLE.
  - No ack: counter increments. When the counter reaches TIMEOUT without ack, err = 1 with code 10 next cycle, sw_req cleared, go to IDLE.
  - An ack in the same cycle the counter hits TIMEOUT wins, producing done rather than err.
- The FIFO may keep accepting operations while in WAIT. Ordering is strictly preserved.

## Timing
- Reset values (asserted asynchronously, released synchronously to clk):
  - sw_req = 0, sw_op_id = 0, done = 0, err = 0, err_code = 0, busy = 0
  - FIFO empty, so in_ready = 1
  - FSM in IDLE, counter 0
- Push at edge t, FIFO previously empty:
  - Pop and decode in cycle t+1.
  - sw_req rises after the edge ending t+1, i.e. 2 cycles after acceptance.
- Ack sampled in cycle k: done high in cycle k+1 and sw_req low in cycle k+1.
  - Pop of the next entry occurs in cycle k+1.
  - The next sw_req rises in k+2, giving at least 1 low cycle between requests.
- Timeout: with no ack, sw_req is high for exactly TIMEOUT cycles. err is asserted in the cycle sw_req drops.
- Decode miss: err is asserted the cycle after the pop. No sw_req activity occurs.
- done and err are never both high. Each is high for exactly one cycle per operation.
- Reset asserted mid-WAIT: sw_req and all outputs drop asynchronously, FIFO contents are discarded, and no done/err pulse is issued.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles, then release. All outputs are 0, in_ready=1 and busy=0 from the first cycle.
- Hit: push addr 0x12, op 0xA5, then assert sw_ack[2] 3 cycles after sw_req rises.
  - sw_req=5'b00100 and slice 2 = 0xA5 for 4 cycles; all other slices are 0.
  - done pulses once; err stays 0.
- Miss: push addr 0x20, then addr 0x0F. err pulses twice with err_code=01 and sw_req stays 0 throughout.
- Timeout: with TIMEOUT=15, push addr 0x10 and never ack. sw_req[0] is high for exactly 15 cycles, then err with code 10. A late ack afterwards has no effect.
- Backpressure/order: push 4 operations back-to-back (0x10..0x13) with acks withheld 5 cycles each.
  - in_ready drops on the 4th offer and is held until the first done.
  - sw_req sequence is 0,1,2,3 and each op id matches its address.
  - A simultaneous ack and timeout on the last operation yields done, not err.
- Reset mid-op: assert rst_n=0 while sw_req[1]=1 and the FIFO holds 2 entries.
  - sw_req drops immediately; no done/err.
  - After release, busy=0 and no stale requests are issued.
